window_stream_buffer: RTL and testbench

- Parametrised successor to the fixed 3x3 row-buffer front end feeding the Sobel and connected-components stages.
- Accepts a raster pixel stream under a valid/ready handshake and emits one KERNEL x KERNEL neighbourhood per input pixel, centred on that pixel, with out-of-frame taps padded.
- Buffers KERNEL-1 image rows in internal line memories.
- Handles frame start, end-of-frame flush and downstream backpressure itself, so downstream kernels (Sobel, box blur, morphology) are pure combinational consumers of the window.

---
 rtl/window_stream_buffer_pkg.sv | 17 +
 rtl/window_stream_buffer_line_ram.sv | 26 ++
 rtl/window_stream_buffer.sv | 200 ++++++++++++++++++++
 tb/tb_window_stream_buffer.sv | 373 +++++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/window_stream_buffer_pkg.sv
// Shared definitions for the sliding-window stream buffer.
package window_stream_buffer_pkg;

    localparam int KERNEL_MAX = 7;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        RUN   = 2'd1,
        FLUSH = 2'd2
    } wsb_state_t;

    // LSB position of tap (r,c) inside a flat row-major window of k*k taps
    function automatic int tap_lsb(input int r, input int c, input int k, input int dw);
        return (r * k + c) * dw;
    endfunction

endpackage

// File: rtl/window_stream_buffer_line_ram.sv
// One image-row delay line: simple dual-port RAM with registered read.
module window_stream_buffer_line_ram
    import window_stream_buffer_pkg::*;
#(
    parameter int DATA_WIDTH = 8,
    parameter int ADDR_WIDTH = 11
)(
    input  logic                  clk,
    input  logic                  wr_en,
    input  logic [ADDR_WIDTH-1:0] wr_addr,
    input  logic [DATA_WIDTH-1:0] wr_data,
    input  logic [ADDR_WIDTH-1:0] rd_addr,
    output logic [DATA_WIDTH-1:0] rd_data
);

    logic [DATA_WIDTH-1:0] mem [2**ADDR_WIDTH];

    // Write port and registered read port; contents are never reset
    always_ff @(posedge clk) begin
        if (wr_en) begin
            mem[wr_addr] <= wr_data;
        end
        rd_data <= mem[rd_addr];
    end

endmodule

// File: rtl/window_stream_buffer.sv
// Raster stream to KERNEL x KERNEL neighbourhood converter with border padding,
// end-of-frame flush and output backpressure handling.
module window_stream_buffer
    import window_stream_buffer_pkg::*;
#(
    parameter int DATA_WIDTH   = 8,
    parameter int FRAME_WIDTH  = 640,
    parameter int FRAME_HEIGHT = 480,
    parameter int KERNEL       = 3,
    parameter int ADDR_WIDTH   = 11,
    parameter logic [DATA_WIDTH-1:0] PAD_VALUE = '0
)(
    input  logic                                 clk,
    input  logic                                 reset,
    input  logic                                 in_valid,
    output logic                                 in_ready,
    input  logic                                 in_sof,
    input  logic [DATA_WIDTH-1:0]                in_data,
    output logic                                 out_valid,
    input  logic                                 out_ready,
    output logic [KERNEL*KERNEL*DATA_WIDTH-1:0]  out_window,
    output logic [15:0]                          out_x,
    output logic [15:0]                          out_y,
    output logic                                 out_eof,
    output logic                                 sof_err
);

    localparam int R     = (KERNEL - 1) / 2;
    localparam int LEAD  = R * FRAME_WIDTH + R;
    localparam int WIN_W = KERNEL * KERNEL * DATA_WIDTH;
    localparam logic [31:0] LEAD_U = 32'(LEAD);
    localparam logic [15:0] LAST_X = 16'(FRAME_WIDTH - 1);
    localparam logic [15:0] LAST_Y = 16'(FRAME_HEIGHT - 1);
    localparam logic signed [16:0] MAX_X = 17'(FRAME_WIDTH - 1);
    localparam logic signed [16:0] MAX_Y = 17'(FRAME_HEIGHT - 1);
    localparam logic signed [16:0] ZERO  = '0;

    wsb_state_t state;
    logic [15:0] in_x, in_y, emit_x, emit_y;
    logic [15:0] cur_x, cur_y, nxt_x, nxt_y;
    logic [31:0] pre_cnt, fl_cnt;
    logic        adv, xfer, restart, inject, shift, emit, last_px;
    logic [DATA_WIDTH-1:0] col_pix;
    logic [ADDR_WIDTH-1:0] rd_addr;
    logic [DATA_WIDTH-1:0] ram_wdata [KERNEL-1];
    logic [DATA_WIDTH-1:0] ram_rdata [KERNEL-1];
    logic [DATA_WIDTH-1:0] newcol    [KERNEL];
    logic [WIN_W-1:0]      win, win_next;

    // Replace every tap whose frame coordinate lies outside the image by PAD_VALUE;
    // this hides row-wrap neighbours, previous-frame data and uninitialised RAM.
    function automatic logic [WIN_W-1:0] pad_window(input logic [WIN_W-1:0] w,
                                                     input logic [15:0] cx,
                                                     input logic [15:0] cy);
        logic signed [16:0] tx, ty;
        pad_window = w;
        for (int r = 0; r < KERNEL; r++) begin
            for (int c = 0; c < KERNEL; c++) begin
                ty = $signed({1'b0, cy}) + $signed(17'(r)) - $signed(17'(R));
                tx = $signed({1'b0, cx}) + $signed(17'(c)) - $signed(17'(R));
                if (ty < ZERO || ty > MAX_Y || tx < ZERO || tx > MAX_X) begin
                    pad_window[tap_lsb(r, c, KERNEL, DATA_WIDTH) +: DATA_WIDTH] = PAD_VALUE;
                end
            end
        end
    endfunction

    assign adv      = !out_valid || out_ready;
    assign in_ready = !reset && ((state == IDLE) || (state == RUN && adv));

    // Handshake decode, raster position of the pixel entering now and RAM read lookahead
    always_comb begin
        xfer    = in_valid && in_ready;
        restart = xfer && in_sof;
        inject  = (state == FLUSH) && adv;
        shift   = restart || (state == RUN && xfer) || inject;
        cur_x   = restart ? 16'd0 : in_x;
        cur_y   = restart ? 16'd0 : in_y;
        nxt_x   = (cur_x == LAST_X) ? 16'd0 : cur_x + 16'd1;
        nxt_y   = (cur_x == LAST_X) ? cur_y + 16'd1 : cur_y;
        last_px = (state == RUN) && xfer && !in_sof && (cur_x == LAST_X) && (cur_y == LAST_Y);
        emit    = shift && !restart && (pre_cnt == LEAD_U);
        col_pix = inject ? PAD_VALUE : in_data;
        // Read the column the next shift will need, so registered read data is ready then
        rd_addr = shift ? nxt_x[ADDR_WIDTH-1:0] : in_x[ADDR_WIDTH-1:0];
    end

    // Line memories chained: RAM i delays row by i+1 lines
    for (genvar i = 0; i < KERNEL - 1; i++) begin : g_line
        if (i == 0) begin : g_first
            assign ram_wdata[i] = col_pix;
        end else begin : g_next
            assign ram_wdata[i] = ram_rdata[i-1];
        end
        window_stream_buffer_line_ram #(
            .DATA_WIDTH(DATA_WIDTH),
            .ADDR_WIDTH(ADDR_WIDTH)
        ) u_line_ram (
            .clk     (clk),
            .wr_en   (shift),
            .wr_addr (cur_x[ADDR_WIDTH-1:0]),
            .wr_data (ram_wdata[i]),
            .rd_addr (rd_addr),
            .rd_data (ram_rdata[i])
        );
    end

    // Next window: shift columns left, newest column enters at the right (oldest row on top)
    always_comb begin
        win_next = win;
        for (int i = 0; i < KERNEL - 1; i++) begin
            newcol[KERNEL-2-i] = ram_rdata[i];
        end
        newcol[KERNEL-1] = col_pix;
        for (int r = 0; r < KERNEL; r++) begin
            for (int c = 0; c < KERNEL - 1; c++) begin
                win_next[tap_lsb(r, c, KERNEL, DATA_WIDTH) +: DATA_WIDTH] =
                    win[tap_lsb(r, c + 1, KERNEL, DATA_WIDTH) +: DATA_WIDTH];
            end
            win_next[tap_lsb(r, KERNEL - 1, KERNEL, DATA_WIDTH) +: DATA_WIDTH] = newcol[r];
        end
    end

    // Raw window shift register (data only, masked on the way out)
    always_ff @(posedge clk) begin
        if (shift) begin
            win <= win_next;
        end
    end

    // FSM, raster counters and registered output stage
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state      <= IDLE;
            in_x       <= '0;
            in_y       <= '0;
            emit_x     <= '0;
            emit_y     <= '0;
            pre_cnt    <= '0;
            fl_cnt     <= '0;
            out_valid  <= 1'b0;
            out_window <= '0;
            out_x      <= '0;
            out_y      <= '0;
            out_eof    <= 1'b0;
            sof_err    <= 1'b0;
        end else begin
            if (shift) begin
                in_x <= nxt_x;
                in_y <= nxt_y;
            end
            if (restart) begin
                pre_cnt <= 32'd1;
                emit_x  <= '0;
                emit_y  <= '0;
                fl_cnt  <= '0;
            end else if (shift) begin
                if (pre_cnt != LEAD_U) begin
                    pre_cnt <= pre_cnt + 32'd1;
                end else if (emit_x == LAST_X) begin
                    emit_x <= '0;
                    emit_y <= emit_y + 16'd1;
                end else begin
                    emit_x <= emit_x + 16'd1;
                end
            end

            case (state)
                IDLE: begin
                    if (restart) state <= RUN;
                end
                RUN: begin
                    if (restart) begin
                        sof_err <= 1'b1;
                    end else if (last_px) begin
                        state <= FLUSH;
                    end
                end
                FLUSH: begin
                    if (inject) begin
                        fl_cnt <= fl_cnt + 32'd1;
                        if (fl_cnt == LEAD_U - 32'd1) state <= IDLE;
                    end
                end
                default: state <= IDLE;
            endcase

            if (adv) begin
                out_valid <= emit;
                out_eof   <= emit && (emit_x == LAST_X) && (emit_y == LAST_Y);
                if (emit) begin
                    out_window <= pad_window(win_next, emit_x, emit_y);
                    out_x      <= emit_x;
                    out_y      <= emit_y;
                end
            end
        end
    end

endmodule

// File: tb/tb_window_stream_buffer.sv
// Bench for window_stream_buffer: a K=3 4x3 instance and a K=5 8x6 instance.
module tb_window_stream_buffer;

    logic clk = 1'b0;
    logic reset;
    logic in_valid, in_sof, out_ready, sel;
    logic [7:0] in_data;

    logic        in_valid1, in_ready1, out_valid1, out_eof1, sof_err1;
    logic [71:0] out_window1;
    logic [15:0] out_x1, out_y1;
    logic        in_valid2, in_ready2, out_valid2, out_eof2, sof_err2;
    logic [199:0] out_window2;
    logic [15:0] out_x2, out_y2;
    logic        in_ready_m;

    assign in_valid1  = in_valid && !sel;
    assign in_valid2  = in_valid && sel;
    assign in_ready_m = sel ? in_ready2 : in_ready1;

    always #5 clk = ~clk;

    window_stream_buffer #(.DATA_WIDTH(8), .FRAME_WIDTH(4), .FRAME_HEIGHT(3), .KERNEL(3),
                           .ADDR_WIDTH(2), .PAD_VALUE(8'h00)) u_dut1 (
        .clk(clk), .reset(reset), .in_valid(in_valid1), .in_ready(in_ready1),
        .in_sof(in_sof), .in_data(in_data), .out_valid(out_valid1), .out_ready(out_ready),
        .out_window(out_window1), .out_x(out_x1), .out_y(out_y1), .out_eof(out_eof1),
        .sof_err(sof_err1));

    window_stream_buffer #(.DATA_WIDTH(8), .FRAME_WIDTH(8), .FRAME_HEIGHT(6), .KERNEL(5),
                           .ADDR_WIDTH(3), .PAD_VALUE(8'hFF)) u_dut2 (
        .clk(clk), .reset(reset), .in_valid(in_valid2), .in_ready(in_ready2),
        .in_sof(in_sof), .in_data(in_data), .out_valid(out_valid2), .out_ready(out_ready),
        .out_window(out_window2), .out_x(out_x2), .out_y(out_y2), .out_eof(out_eof2),
        .sof_err(sof_err2));

    typedef struct {
        logic [199:0] win;
        int           x;
        int           y;
        logic         eof;
    } exp_t;

    typedef struct {
        int           s;
        int           x;
        int           y;
        logic [199:0] win;
    } tab_t;

    exp_t q1[$];
    exp_t q2[$];
    logic [7:0]   frame_pix [0:63];
    logic [199:0] cap1 [0:11];
    logic [199:0] cap2 [0:47];
    tab_t tab [5];
    int n_checks = 0;
    int n_fail   = 0;
    int npop1    = 0;
    int gap      = -1;
    int max_gap  = 0;
    int or_mode  = 0;
    logic chk_inready = 1'b0;

    task automatic check(input string name, input logic [199:0] act, input logic [199:0] req);
        n_checks++;
        if (act !== req) begin
            n_fail++;
            $display("FAIL %s: got %0h, expected %0h", name, act, req);
        end
    endtask

    function automatic int kk(input int s); return s ? 5 : 3; endfunction
    function automatic int ww(input int s); return s ? 8 : 4; endfunction
    function automatic int hh(input int s); return s ? 6 : 3; endfunction

    // Direct neighbourhood computation from the frame contents
    function automatic logic [199:0] model_win(input int s, input int x, input int y);
        logic [199:0] m;
        int k, w, h, rr, xx, yy;
        logic [7:0] pad;
        k = kk(s); w = ww(s); h = hh(s); rr = (k - 1) / 2;
        pad = s ? 8'hFF : 8'h00;
        m = '0;
        for (int r = 0; r < k; r++) begin
            for (int c = 0; c < k; c++) begin
                yy = y + r - rr;
                xx = x + c - rr;
                if (yy < 0 || yy >= h || xx < 0 || xx >= w) m[(r*k+c)*8 +: 8] = pad;
                else m[(r*k+c)*8 +: 8] = frame_pix[yy*w+xx];
            end
        end
        return m;
    endfunction

    task automatic push_frame(input int s, input int nwin);
        exp_t e;
        for (int n = 0; n < nwin; n++) begin
            e.x   = n % ww(s);
            e.y   = n / ww(s);
            e.win = model_win(s, e.x, e.y);
            e.eof = (e.x == ww(s) - 1) && (e.y == hh(s) - 1);
            if (s == 0) q1.push_back(e);
            else q2.push_back(e);
        end
    endtask

    function automatic logic [199:0] pack9(input int v [9]);
        logic [199:0] m;
        m = '0;
        for (int i = 0; i < 9; i++) m[i*8 +: 8] = 8'(v[i]);
        return m;
    endfunction

    task automatic send(input logic [7:0] d, input logic sof);
        int t;
        t = 0;
        @(negedge clk);
        in_valid = 1'b1;
        in_data  = d;
        in_sof   = sof;
        while (!in_ready_m && t < 200) begin
            @(negedge clk);
            t++;
        end
        if (t >= 200) begin
            n_checks++;
            n_fail++;
            $display("FAIL send_timeout: in_ready stayed 0 for %0d cycles", t);
        end
        @(posedge clk);
    endtask

    task automatic send_frame(input int n, input int first_sof);
        for (int i = 0; i < n; i++) send(frame_pix[i], (i == 0) && (first_sof != 0));
    endtask

    task automatic stop_input();
        @(negedge clk);
        in_valid = 1'b0;
        in_sof   = 1'b0;
    endtask

    task automatic drain(input int s);
        int t;
        t = 0;
        while (((s == 0) ? q1.size() : q2.size()) != 0 && t < 500) begin
            @(negedge clk);
            t++;
        end
        n_checks++;
        if (((s == 0) ? q1.size() : q2.size()) != 0) begin
            n_fail++;
            $display("FAIL drain_%0d: %0d windows still expected", s, (s == 0) ? q1.size() : q2.size());
        end
        repeat (4) @(negedge clk);
    endtask

    task automatic ready_gen();
        int cyc;
        logic pat [4];
        pat = '{1'b1, 1'b0, 1'b0, 1'b1};
        cyc = 0;
        forever begin
            @(posedge clk);
            #1;
            out_ready = (or_mode == 0) ? 1'b1 : pat[cyc % 4];
            cyc++;
        end
    endtask

    // Scoreboard pop, hold-stability and stall checks for one instance
    task automatic monitor(input int s);
        logic held, v, eof;
        logic [199:0] w, hw;
        logic [15:0] x, y, hx, hy;
        logic he;
        exp_t e;
        held = 1'b0; hw = '0; hx = '0; hy = '0; he = 1'b0;
        forever begin
            @(negedge clk);
            if (reset) begin
                held = 1'b0;
                continue;
            end
            v   = s ? out_valid2 : out_valid1;
            w   = s ? out_window2 : 200'(out_window1);
            x   = s ? out_x2 : out_x1;
            y   = s ? out_y2 : out_y1;
            eof = s ? out_eof2 : out_eof1;
            if (held) begin
                check("hold_valid", 200'(v), 200'(1));
                check("hold_window", w, hw);
                check("hold_xy", 200'({x, y}), 200'({hx, hy}));
                check("hold_eof", 200'(eof), 200'(he));
            end
            if (v && out_ready) begin
                if (((s == 0) ? q1.size() : q2.size()) == 0) begin
                    n_checks++;
                    n_fail++;
                    $display("FAIL unexpected_window dut%0d: got window at (%0d,%0d), expected none", s, x, y);
                end else begin
                    e = (s == 0) ? q1.pop_front() : q2.pop_front();
                    check("win_taps", w, e.win);
                    check("win_x", 200'(x), 200'(e.x));
                    check("win_y", 200'(y), 200'(e.y));
                    check("win_eof", 200'(eof), 200'(e.eof));
                    if (s == 0) begin
                        npop1++;
                        if (x < 4 && y < 3) cap1[y*4+x] = w;
                    end else if (x < 8 && y < 6) begin
                        cap2[y*8+x] = w;
                    end
                end
            end
            if (s == 0 && chk_inready && v && !out_ready)
                check("in_ready_stall", 200'(in_ready1), 200'(0));
            if (s == 0) begin
                if (v) begin
                    if (gap > max_gap) max_gap = gap;
                    gap = 0;
                end else if (gap >= 0) begin
                    gap++;
                end
            end
            held = v && !out_ready;
            hw = w; hx = x; hy = y; he = eof;
        end
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int t00 [9];
        int t11 [9];
        int t32 [9];
        logic [199:0] k00, k33;

        in_valid = 1'b0; in_sof = 1'b0; in_data = '0; sel = 1'b0;
        out_ready = 1'b1; reset = 1'b1;
        fork
            monitor(0);
            monitor(1);
            ready_gen();
        join_none

        // Reset values
        repeat (3) @(negedge clk);
        check("rst_out_valid", 200'(out_valid1), 200'(0));
        check("rst_in_ready", 200'(in_ready1), 200'(0));
        check("rst_out_window", 200'(out_window1), 200'(0));
        check("rst_out_xy", 200'({out_x1, out_y1}), 200'(0));
        check("rst_out_eof", 200'(out_eof1), 200'(0));
        check("rst_sof_err", 200'(sof_err1), 200'(0));
        check("rst_out_valid2", 200'(out_valid2), 200'(0));
        reset = 1'b0;

        // K=3 frame of pixels 1..12, out_ready held high
        for (int i = 0; i < 12; i++) frame_pix[i] = 8'(i + 1);
        push_frame(0, 12);
        send_frame(12, 1);
        stop_input();
        drain(0);

        // K=5 constant frame with 0xFF padding
        for (int i = 0; i < 48; i++) frame_pix[i] = 8'h10;
        sel = 1'b1;
        push_frame(1, 48);
        send_frame(48, 1);
        stop_input();
        drain(1);
        sel = 1'b0;

        // Spot windows from the two frames above
        t00 = '{0, 0, 0, 0, 1, 2, 0, 5, 6};
        t11 = '{1, 2, 3, 5, 6, 7, 9, 10, 11};
        t32 = '{7, 8, 0, 11, 12, 0, 0, 0, 0};
        k00 = '0;
        k33 = '0;
        for (int r = 0; r < 5; r++)
            for (int c = 0; c < 5; c++) begin
                k00[(r*5+c)*8 +: 8] = (r < 2 || c < 2) ? 8'hFF : 8'h10;
                k33[(r*5+c)*8 +: 8] = 8'h10;
            end
        tab[0] = '{s: 0, x: 0, y: 0, win: pack9(t00)};
        tab[1] = '{s: 0, x: 1, y: 1, win: pack9(t11)};
        tab[2] = '{s: 0, x: 3, y: 2, win: pack9(t32)};
        tab[3] = '{s: 1, x: 0, y: 0, win: k00};
        tab[4] = '{s: 1, x: 3, y: 3, win: k33};
        for (int i = 0; i < 5; i++) begin
            if (tab[i].s == 0) check($sformatf("table_k3_%0d_%0d", tab[i].x, tab[i].y),
                                     cap1[tab[i].y*4+tab[i].x], tab[i].win);
            else check($sformatf("table_k5_%0d_%0d", tab[i].x, tab[i].y),
                       cap2[tab[i].y*8+tab[i].x], tab[i].win);
        end

        // Same K=3 stream under 1,0,0,1 backpressure
        for (int i = 0; i < 12; i++) frame_pix[i] = 8'(i + 1);
        or_mode = 1;
        push_frame(0, 12);
        send(frame_pix[0], 1'b1);
        chk_inready = 1'b1;
        for (int i = 1; i < 12; i++) send(frame_pix[i], 1'b0);
        chk_inready = 1'b0;
        stop_input();
        drain(0);
        or_mode = 0;
        repeat (2) @(negedge clk);

        // Mid-frame sof: six pixels of frame A, then a full frame B
        check("sof_err_before", 200'(sof_err1), 200'(0));
        for (int i = 0; i < 12; i++) frame_pix[i] = 8'(i + 21);
        push_frame(0, 1);
        send_frame(6, 1);
        for (int i = 0; i < 12; i++) frame_pix[i] = 8'(i + 1);
        push_frame(0, 12);
        send(frame_pix[0], 1'b1);
        @(negedge clk);
        check("sof_err_after", 200'(sof_err1), 200'(1));
        for (int i = 1; i < 12; i++) send(frame_pix[i], 1'b0);
        stop_input();
        drain(0);

        // Reset asserted while flushing
        for (int i = 0; i < 12; i++) frame_pix[i] = 8'(i + 41);
        push_frame(0, 12);
        send_frame(12, 1);
        @(negedge clk);
        in_valid = 1'b0;
        in_sof   = 1'b0;
        #2;
        reset = 1'b1;
        #1;
        check("midflush_out_valid", 200'(out_valid1), 200'(0));
        check("midflush_in_ready", 200'(in_ready1), 200'(0));
        check("midflush_out_window", 200'(out_window1), 200'(0));
        check("midflush_sof_err", 200'(sof_err1), 200'(0));
        q1.delete();
        @(negedge clk);
        reset = 1'b0;
        for (int i = 0; i < 12; i++) frame_pix[i] = 8'(i + 61);
        push_frame(0, 12);
        send_frame(12, 1);
        stop_input();
        drain(0);

        // Back-to-back frames with the next sof waiting during flush
        for (int i = 0; i < 12; i++) frame_pix[i] = 8'(i + 1);
        push_frame(0, 12);
        push_frame(0, 12);
        npop1   = 0;
        max_gap = 0;
        gap     = -1;
        send_frame(12, 1);
        send_frame(12, 1);
        stop_input();
        drain(0);
        check("b2b_window_count", 200'(npop1), 200'(24));
        n_checks++;
        if (max_gap > 5) begin
            n_fail++;
            $display("FAIL b2b_gap: got %0d idle cycles, expected at most 5", max_gap);
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
